acs_pm_array: RTL and testbench

//  Add-compare-select stage of the rate-1/2 Viterbi decoder; sits directly downstream of the branch metric units.

---
 rtl/acs_pm_array_if.sv | 37 +++
 rtl/acs_pm_array.sv | 141 ++++++++++++++
 tb/tb_acs_pm_array.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/acs_pm_array_if.sv
// Handshake/bus bundle between the branch-metric units, the ACS stage and traceback.
// slave = ACS stage side, master = producer/consumer side.
interface acs_pm_array_if #(
  parameter int K = 7
);
  localparam int NS = 1 << (K - 1);

  logic          in_valid;
  logic          in_ready;
  logic          in_sof;
  logic          in_eof;
  logic [1:0]    bm00;
  logic [1:0]    bm01;
  logic [1:0]    bm10;
  logic [1:0]    bm11;
  logic          out_valid;
  logic          out_ready;
  logic [NS-1:0] out_dec;
  logic [K-2:0]  out_best_state;
  logic          out_eof;

  modport slave (
    input  in_valid, in_sof, in_eof,
    input  bm00, bm01, bm10, bm11,
    input  out_ready,
    output in_ready,
    output out_valid, out_dec, out_best_state, out_eof
  );

  modport master (
    output in_valid, in_sof, in_eof,
    output bm00, bm01, bm10, bm11,
    output out_ready,
    input  in_ready,
    input  out_valid, out_dec, out_best_state, out_eof
  );
endinterface

// File: rtl/acs_pm_array.sv
// Rate-1/2 Viterbi add-compare-select over all 2^(K-1) states, MSB renormalisation.
// Define ACS_BEST_STATE_EN to build the minimum-metric search for out_best_state.
module acs_pm_array #(
  parameter int           K         = 7,
  parameter int           PM_W      = 8,
  parameter logic [K-1:0] G0        = 7'o171,
  parameter logic [K-1:0] G1        = 7'o133,
  parameter int           INIT_BIAS = 64
) (
  input logic           clk,
  input logic           rst_n,
  acs_pm_array_if.slave bus
);

  localparam int NS = 1 << (K - 1);

  typedef logic [PM_W-1:0] pm_t;
  typedef logic [PM_W:0]   sum_t;

  pm_t          r_pm [NS];
  logic         r_ov;
  logic [NS-1:0] r_dec;
  logic [K-2:0] r_best;
  logic         r_eof;

  logic         w_rdy;
  logic         w_acc;
  logic [1:0]   w_bm [4];
  pm_t          w_src [NS];
  pm_t          w_raw [NS];
  pm_t          w_pmn [NS];
  logic [NS-1:0] w_dec;
  logic         w_all;
  logic [K-2:0] w_best;

  function automatic logic [1:0] code(input logic [K-1:0] r);
    return {^(r & G1), ^(r & G0)};
  endfunction

  assign w_rdy = ~r_ov | bus.out_ready;
  assign w_acc = bus.in_valid & w_rdy;

  assign w_bm[0] = bus.bm00;
  assign w_bm[1] = bus.bm01;
  assign w_bm[2] = bus.bm10;
  assign w_bm[3] = bus.bm11;

  // A frame start ignores stored metrics and uses the initial profile.
  always_comb begin
    for (int s = 0; s < NS; s++) begin
      if (bus.in_sof)
        w_src[s] = (s == 0) ? '0 : pm_t'(INIT_BIAS);
      else
        w_src[s] = r_pm[s];
    end
  end

  always_comb begin
    w_dec = '0;
    w_all = 1'b1;
    for (int n = 0; n < NS; n++) begin
      logic [K-2:0] nv;
      logic [K-2:0] p0;
      logic [K-2:0] p1;
      sum_t         m0;
      sum_t         m1;
      nv = (K-1)'(n);
      p0 = {nv[K-3:0], 1'b0};
      p1 = {nv[K-3:0], 1'b1};
      m0 = sum_t'(w_src[p0])
         + sum_t'(w_bm[code({nv[K-2], p0})]);
      m1 = sum_t'(w_src[p1])
         + sum_t'(w_bm[code({nv[K-2], p1})]);
      w_dec[n] = m1 < m0;
      w_raw[n] = w_dec[n] ? m1[PM_W-1:0]
                          : m0[PM_W-1:0];
      w_all = w_all & w_raw[n][PM_W-1];
    end
  end

  // Common MSB set everywhere: drop it from all metrics together.
  always_comb begin
    for (int n = 0; n < NS; n++) begin
      w_pmn[n] = w_raw[n];
      if (w_all)
        w_pmn[n][PM_W-1] = 1'b0;
    end
  end

`ifdef ACS_BEST_STATE_EN
  // Heap-ordered binary tree; left subtree holds lower indices.
  always_comb begin
    pm_t          tv [2*NS-1];
    logic [K-2:0] ti [2*NS-1];
    for (int i = 0; i < NS; i++) begin
      tv[NS-1+i] = w_pmn[i];
      ti[NS-1+i] = (K-1)'(i);
    end
    for (int j = NS - 2; j >= 0; j--) begin
      if (tv[2*j+2] < tv[2*j+1]) begin
        tv[j] = tv[2*j+2];
        ti[j] = ti[2*j+2];
      end else begin
        tv[j] = tv[2*j+1];
        ti[j] = ti[2*j+1];
      end
    end
    w_best = ti[0];
  end
`else
  assign w_best = '0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < NS; s++)
        r_pm[s] <= (s == 0) ? '0 : pm_t'(INIT_BIAS);
      r_ov   <= 1'b0;
      r_dec  <= '0;
      r_best <= '0;
      r_eof  <= 1'b0;
    end else begin
      if (w_acc) begin
        r_pm   <= w_pmn;
        r_dec  <= w_dec;
        r_best <= w_best;
        r_eof  <= bus.in_eof;
        r_ov   <= 1'b1;
      end else if (bus.out_ready) begin
        r_ov <= 1'b0;
      end
    end
  end

  assign bus.in_ready       = w_rdy;
  assign bus.out_valid      = r_ov;
  assign bus.out_dec        = r_dec;
  assign bus.out_best_state = r_best;
  assign bus.out_eof        = r_eof;

endmodule

// File: tb/tb_acs_pm_array.sv
// Randomised bench for acs_pm_array against a forward-trellis metric model.
// Model metrics are unbounded integers; renormalisation must not change outcomes.
module tb_acs_pm_array;

  localparam int K  = 7;
  localparam int NS = 1 << (K - 1);
  localparam int G0 = 'o171;
  localparam int G1 = 'o133;
  localparam int IB = 64;

  logic clk;
  logic rst_n;

  acs_pm_array_if #(.K(K)) bus ();

  acs_pm_array dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int            n_cmp;
  int            n_bad;
  int            mpm [NS];
  logic [NS-1:0] exp_dec;
  logic [K-2:0]  exp_best;
  logic          exp_eof;

  task automatic model_init();
    for (int s = 0; s < NS; s++)
      mpm[s] = (s == 0) ? 0 : IB;
  endtask

  // Forward trellis: every state p with input u reaches n = {u, p>>1}.
  task automatic model_step(input int a00, input int a01,
                            input int a10, input int a11,
                            input bit sof);
    int b [4];
    int m0 [NS];
    int m1 [NS];
    int nx [NS];
    int mn;
    int bi;
    b[0] = a00; b[1] = a01; b[2] = a10; b[3] = a11;
    if (sof) model_init();
    for (int p = 0; p < NS; p++) begin
      for (int u = 0; u < 2; u++) begin
        int r, c0, c1, n, m;
        r  = (u << (K - 1)) | p;
        c0 = $countones(r & G0) % 2;
        c1 = $countones(r & G1) % 2;
        n  = (u << (K - 2)) | (p >> 1);
        m  = mpm[p] + b[c1 * 2 + c0];
        if (p % 2 == 1) m1[n] = m;
        else m0[n] = m;
      end
    end
    mn = 1 << 30;
    bi = 0;
    for (int n = 0; n < NS; n++) begin
      exp_dec[n] = (m1[n] < m0[n]);
      nx[n] = (m1[n] < m0[n]) ? m1[n] : m0[n];
      if (nx[n] < mn) begin
        mn = nx[n];
        bi = n;
      end
    end
    for (int n = 0; n < NS; n++) mpm[n] = nx[n];
`ifdef ACS_BEST_STATE_EN
    exp_best = (K-1)'(bi);
`else
    exp_best = '0;
`endif
  endtask

  task automatic drive(input int a00, input int a01,
                       input int a10, input int a11,
                       input bit sof, input bit eof);
    bus.in_valid = 1'b1;
    bus.bm00 = 2'(a00);
    bus.bm01 = 2'(a01);
    bus.bm10 = 2'(a10);
    bus.bm11 = 2'(a11);
    bus.in_sof = sof;
    bus.in_eof = eof;
  endtask

  task automatic beat(input int a00, input int a01,
                      input int a10, input int a11,
                      input bit sof, input bit eof);
    drive(a00, a01, a10, a11, sof, eof);
    @(posedge clk);
    #1;
    model_step(a00, a01, a10, a11, sof);
    exp_eof = eof;
    bus.in_valid = 1'b0;
    bus.in_sof = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_init();
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.out_dec !== '0 ||
        bus.out_best_state !== '0 || bus.out_eof !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: ov=%b dec=%h best=%0d eof=%b want 0/0/0/0",
               bus.out_valid, bus.out_dec, bus.out_best_state, bus.out_eof);
    end
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_zero_bm();
    for (int i = 0; i < 12; i++) begin
      beat(0, 1, 1, 2, 1'b0, i == 11);
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.out_dec !== exp_dec ||
          bus.out_best_state !== exp_best || bus.out_eof !== exp_eof) begin
        n_bad++;
        $display("FAIL zero_bm[%0d]: ov=%b dec=%h best=%0d eof=%b want 1 %h %0d %b",
                 i, bus.out_valid, bus.out_dec, bus.out_best_state,
                 bus.out_eof, exp_dec, exp_best, exp_eof);
      end
    end
  endtask

  task automatic test_encode_5a3();
    int es;
    es = 0;
    for (int i = 0; i < 12; i++) begin
      int u, r, c0, c1;
      int b [4];
      u  = ('h5A3 >> i) & 1;
      r  = (u << (K - 1)) | es;
      c0 = $countones(r & G0) % 2;
      c1 = $countones(r & G1) % 2;
      es = r >> 1;
      for (int x = 0; x < 4; x++)
        b[x] = ((x & 1) ^ c0) + (((x >> 1) & 1) ^ c1);
      beat(b[0], b[1], b[2], b[3], i == 0, i == 11);
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.out_dec !== exp_dec ||
          bus.out_best_state !== exp_best || bus.out_eof !== exp_eof) begin
        n_bad++;
        $display("FAIL enc5a3[%0d]: ov=%b dec=%h best=%0d eof=%b want 1 %h %0d %b",
                 i, bus.out_valid, bus.out_dec, bus.out_best_state,
                 bus.out_eof, exp_dec, exp_best, exp_eof);
      end
`ifdef ACS_BEST_STATE_EN
      n_cmp++;
      if (bus.out_best_state !== (K-1)'(es)) begin
        n_bad++;
        $display("FAIL enc5a3_path[%0d]: best=%0d want encoder state %0d",
                 i, bus.out_best_state, es);
      end
`else
      n_cmp++;
      if (bus.out_best_state !== '0) begin
        n_bad++;
        $display("FAIL enc5a3_best0[%0d]: best=%0d want 0",
                 i, bus.out_best_state);
      end
`endif
    end
  endtask

  task automatic test_backpressure();
    logic [NS-1:0] hd;
    logic [K-2:0]  hb;
    int            c [4];
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    drive(2, 0, 1, 1, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    model_step(2, 0, 1, 1, 1'b0);
    exp_eof = 1'b1;
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.out_dec !== exp_dec ||
        bus.out_best_state !== exp_best || bus.out_eof !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_first: ov=%b dec=%h best=%0d eof=%b want 1 %h %0d 1",
               bus.out_valid, bus.out_dec, bus.out_best_state, bus.out_eof,
               exp_dec, exp_best);
    end
    hd = exp_dec;
    hb = exp_best;
    for (int x = 0; x < 4; x++) c[x] = $urandom_range(0, 2);
    drive(c[0], c[1], c[2], c[3], 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (bus.in_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL bp_in_ready[%0d]: got %b want 0", k, bus.in_ready);
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.out_dec !== hd ||
          bus.out_best_state !== hb || bus.out_eof !== 1'b1) begin
        n_bad++;
        $display("FAIL bp_hold[%0d]: ov=%b dec=%h best=%0d eof=%b want 1 %h %0d 1",
                 k, bus.out_valid, bus.out_dec, bus.out_best_state,
                 bus.out_eof, hd, hb);
      end
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    model_step(c[0], c[1], c[2], c[3], 1'b0);
    bus.in_valid = 1'b0;
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.out_dec !== exp_dec ||
        bus.out_best_state !== exp_best || bus.out_eof !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_release: ov=%b dec=%h best=%0d eof=%b want 1 %h %0d 0",
               bus.out_valid, bus.out_dec, bus.out_best_state, bus.out_eof,
               exp_dec, exp_best);
    end
  endtask

  task automatic test_renorm();
    for (int i = 0; i < 80; i++) begin
      beat(2, 2, 2, 0, 1'b0, 1'b0);
      n_cmp++;
      if (bus.out_dec !== exp_dec || bus.out_best_state !== exp_best) begin
        n_bad++;
        $display("FAIL renorm[%0d]: dec=%h best=%0d want %h %0d",
                 i, bus.out_dec, bus.out_best_state, exp_dec, exp_best);
      end
    end
  endtask

  task automatic test_sof_restart();
    for (int i = 1; i <= 30; i++) begin
      int b [4];
      bit eof;
      for (int x = 0; x < 4; x++) b[x] = $urandom_range(0, 2);
      eof = 1'($urandom_range(0, 1));
      beat(b[0], b[1], b[2], b[3], (i == 1) || (i == 20), eof);
      n_cmp++;
      if (bus.out_dec !== exp_dec || bus.out_best_state !== exp_best ||
          bus.out_eof !== exp_eof) begin
        n_bad++;
        $display("FAIL sof_restart[%0d]: dec=%h best=%0d eof=%b want %h %0d %b",
                 i, bus.out_dec, bus.out_best_state, bus.out_eof,
                 exp_dec, exp_best, exp_eof);
      end
    end
  endtask

  task automatic test_random_gaps();
    for (int i = 0; i < 40; i++) begin
      int b [4];
      int gap;
      gap = $urandom_range(0, 2);
      if (gap > 0) begin
        repeat (gap) @(posedge clk);
        #1;
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
          n_bad++;
          $display("FAIL gap_idle[%0d]: ov=%b want 0", i, bus.out_valid);
        end
      end
      for (int x = 0; x < 4; x++) b[x] = $urandom_range(0, 2);
      beat(b[0], b[1], b[2], b[3], 1'b0, 1'($urandom_range(0, 1)));
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.out_dec !== exp_dec ||
          bus.out_best_state !== exp_best || bus.out_eof !== exp_eof) begin
        n_bad++;
        $display("FAIL gap_beat[%0d]: ov=%b dec=%h best=%0d eof=%b want 1 %h %0d %b",
                 i, bus.out_valid, bus.out_dec, bus.out_best_state,
                 bus.out_eof, exp_dec, exp_best, exp_eof);
      end
    end
  endtask

  task automatic test_reset_mid();
    int b [4];
    beat(1, 0, 2, 1, 1'b0, 1'b1);
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if (bus.out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL rmid_pre: ov=%b want 1", bus.out_valid);
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    model_init();
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.out_dec !== '0 ||
        bus.out_best_state !== '0 || bus.out_eof !== 1'b0 ||
        bus.in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL rmid_clear: ov=%b dec=%h best=%0d eof=%b rdy=%b want 0 0 0 0 1",
               bus.out_valid, bus.out_dec, bus.out_best_state,
               bus.out_eof, bus.in_ready);
    end
    for (int i = 0; i < 4; i++) begin
      for (int x = 0; x < 4; x++) b[x] = $urandom_range(0, 2);
      beat(b[0], b[1], b[2], b[3], 1'b0, 1'b0);
      n_cmp++;
      if (bus.out_dec !== exp_dec || bus.out_best_state !== exp_best) begin
        n_bad++;
        $display("FAIL rmid_init[%0d]: dec=%h best=%0d want %h %0d",
                 i, bus.out_dec, bus.out_best_state, exp_dec, exp_best);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_sof = 1'b0;
    bus.in_eof = 1'b0;
    bus.bm00 = '0;
    bus.bm01 = '0;
    bus.bm10 = '0;
    bus.bm11 = '0;
    bus.out_ready = 1'b1;
    exp_dec = '0;
    exp_best = '0;
    exp_eof = 1'b0;
    test_reset();
    test_zero_bm();
    test_encode_5a3();
    test_backpressure();
    test_renorm();
    test_sof_restart();
    test_random_gaps();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
